// File: rtl/memory_round_engine.sv
// memory_round_engine: generates, displays and checks one memory-game round.
// Define ROUND_TIMEOUT_EN to lose the round after TIMEOUT_CYCLES idle input cycles.
module memory_round_engine #(
   parameter int          SHOW_CYCLES    = 8,
   parameter int          GAP_CYCLES     = 4,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       auth_bit,
   input  logic       log_out,
   input  logic       start,
   input  logic [3:0] level_num,
   input  logic       key_valid,
   input  logic [1:0] key,
   output logic       show_valid,
   output logic [1:0] show_sym,
   output logic       input_ready,
   output logic [3:0] progress,
   output logic       busy,
   output logic       win,
   output logic       lose
);

   localparam int PW = 16;
`ifdef ROUND_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [3:0]    len_q, len_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    progress_q, progress_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          show_valid_q, show_valid_d;
   logic [1:0]    show_sym_q, show_sym_d;
   logic          input_ready_q, input_ready_d;
   logic          busy_q, busy_d;
   logic          win_q, win_d;
   logic          lose_q, lose_d;
   logic [1:0]    seq_q [16];
   logic          wr_en;
   logic          abort, show_end, gap_end, to_hit, key_ok;

   assign abort    = log_out | ~auth_bit;
   assign show_end = ph_q == PW'(SHOW_CYCLES - 1);
   assign gap_end  = ph_q == PW'(GAP_CYCLES - 1);
   assign to_hit   = TO_EN && (ph_q == PW'(TIMEOUT_CYCLES - 1));
   assign key_ok   = key == seq_q[progress_q];

   always_comb begin
      state_d    = state_q;
      lfsr_d     = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      len_d      = len_q;
      idx_d      = idx_q;
      progress_d = progress_q;
      ph_d       = ph_q;
      wr_en      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && auth_bit) begin
               state_d    = S_GEN;
               len_d      = level_num;
               idx_d      = 4'd0;
               progress_d = 4'd0;
            end
         end
         S_GEN: begin
            wr_en = 1'b1;
            if (idx_q == len_q) begin
               state_d = S_SHOW;
               idx_d   = 4'd0;
               ph_d    = '0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_SHOW: begin
            if (show_end) begin
               state_d = S_GAP;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         S_GAP: begin
            if (!gap_end) begin
               ph_d = ph_q + 1'b1;
            end else if (idx_q == len_q) begin
               state_d = S_INPUT;
               idx_d   = 4'd0;
               ph_d    = '0;
            end else begin
               state_d = S_SHOW;
               idx_d   = idx_q + 4'd1;
               ph_d    = '0;
            end
         end
         S_INPUT: begin
            if (key_valid) begin
               ph_d = '0;
               if (!key_ok)
                  state_d = S_LOSE;
               else if (progress_q == len_q)
                  state_d = S_WIN;
               else
                  progress_d = progress_q + 4'd1;
            end else if (to_hit) begin
               state_d = S_LOSE;
            end else if (TO_EN) begin
               ph_d = ph_q + 1'b1;
            end
         end
         S_WIN, S_LOSE: begin
            state_d    = S_IDLE;
            progress_d = 4'd0;
            idx_d      = 4'd0;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort outranks everything, including a final correct key.
      if (abort) begin
         state_d    = S_IDLE;
         progress_d = 4'd0;
         idx_d      = 4'd0;
         ph_d       = '0;
         wr_en      = 1'b0;
      end
      show_valid_d  = state_d == S_SHOW;
      input_ready_d = state_d == S_INPUT;
      busy_d        = state_d != S_IDLE;
      win_d         = state_d == S_WIN;
      lose_d        = state_d == S_LOSE;
      show_sym_d    = 2'b00;
      if (state_d == S_SHOW)
         show_sym_d = (wr_en && idx_q == idx_d) ? lfsr_q[1:0]
                                                : seq_q[idx_d];
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         seq_q[idx_q] <= lfsr_q[1:0];
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         lfsr_q        <= LFSR_SEED;
         len_q         <= 4'd0;
         idx_q         <= 4'd0;
         progress_q    <= 4'd0;
         ph_q          <= '0;
         show_valid_q  <= 1'b0;
         show_sym_q    <= 2'b00;
         input_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         progress_q    <= progress_d;
         ph_q          <= ph_d;
         show_valid_q  <= show_valid_d;
         show_sym_q    <= show_sym_d;
         input_ready_q <= input_ready_d;
         busy_q        <= busy_d;
         win_q         <= win_d;
         lose_q        <= lose_d;
      end
   end

   assign show_valid  = show_valid_q;
   assign show_sym    = show_sym_q;
   assign input_ready = input_ready_q;
   assign progress    = progress_q;
   assign busy        = busy_q;
   assign win         = win_q;
   assign lose        = lose_q;

endmodule

// File: tb/tb_memory_round_engine.sv
// Bench for memory_round_engine: timeline model of a round plus directed scenarios.
// Timeout scenarios run when ROUND_TIMEOUT_EN is defined.
module tb_memory_round_engine;

   localparam int SC = 8;
   localparam int GC = 4;
   localparam int TC = 64;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int HN = 8192;
`ifdef ROUND_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock;
   logic       rst;
   logic       auth_bit, log_out, start, key_valid;
   logic [3:0] level_num;
   logic [1:0] key;
   logic       show_valid, input_ready, busy, win, lose;
   logic [1:0] show_sym;
   logic [3:0] progress;

   memory_round_engine #(
      .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
      .TIMEOUT_CYCLES(TC), .LFSR_SEED(SEED)
   ) dut (
      .clock(clock), .rst(rst), .auth_bit(auth_bit),
      .log_out(log_out), .start(start), .level_num(level_num),
      .key_valid(key_valid), .key(key),
      .show_valid(show_valid), .show_sym(show_sym),
      .input_ready(input_ready), .progress(progress),
      .busy(busy), .win(win), .lose(lose)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: round timeline by arithmetic, LFSR history indexed by edge count.
   int cyc, t0, mL, mprog, mto, mode;
   bit mwin;
   logic [15:0] m_lfsr;
   logic [15:0] hist [0:HN-1];

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   always @(posedge clock or posedge rst) begin
      if (rst) begin
         cyc <= 0; m_lfsr <= SEED; hist[0] <= SEED;
         mode <= 0; mprog <= 0; mto <= 0; mwin <= 1'b0;
         t0 <= 0; mL <= 1;
      end else begin
         cyc <= cyc + 1;
         m_lfsr <= step(m_lfsr);
         hist[(cyc + 1) % HN] <= step(m_lfsr);
         if (log_out || !auth_bit) begin
            mode <= 0; mprog <= 0;
         end else begin
            case (mode)
               0: if (start) begin
                  mode <= 1; t0 <= cyc + 1; mL <= int'(level_num) + 1;
               end
               1: if (cyc + 1 - t0 == mL * (1 + SC + GC)) begin
                  mode <= 2; mto <= 0;
               end
               2: if (key_valid) begin
                  mto <= 0;
                  if (key != hist[(t0 + mprog) % HN][1:0]) begin
                     mode <= 3; mwin <= 1'b0;
                  end else if (mprog == mL - 1) begin
                     mode <= 3; mwin <= 1'b1;
                  end else begin
                     mprog <= mprog + 1;
                  end
               end else if (TO_EN) begin
                  if (mto + 1 == TC) begin
                     mode <= 3; mwin <= 1'b0;
                  end else begin
                     mto <= mto + 1;
                  end
               end
               default: begin
                  mode <= 0; mprog <= 0;
               end
            endcase
         end
      end
   end

   function automatic int exp_sv();
      int e;
      if (mode != 1) return 0;
      e = cyc - t0;
      if (e < mL) return 0;
      return (((e - mL) % (SC + GC)) < SC) ? 1 : 0;
   endfunction

   function automatic int exp_sym();
      int e;
      e = cyc - t0 - mL;
      return int'(hist[(t0 + e / (SC + GC)) % HN][1:0]);
   endfunction

   always @(negedge clock) begin
      if (!rst) begin
         chk("busy", int'(busy), (mode != 0) ? 1 : 0);
         chk("show_valid", int'(show_valid), exp_sv());
         chk("input_ready", int'(input_ready), (mode == 2) ? 1 : 0);
         chk("progress", int'(progress), mprog);
         chk("win", int'(win), (mode == 3 && mwin) ? 1 : 0);
         chk("lose", int'(lose), (mode == 3 && !mwin) ? 1 : 0);
         if (exp_sv() == 1)
            chk("show_sym", int'(show_sym), exp_sym());
      end
   end

   logic [1:0] cap [0:15];
   int ncap;
   int t_show, t_ir, n;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [1:0] k);
      key = k; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic run_to_input(input logic [3:0] lvl, input bit noise,
                               output int ts, output int ti);
      int i;
      bit prev;
      level_num = lvl; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_rise", int'(busy), 1);
      ncap = 0; prev = 1'b0; ts = -1; i = 0;
      while (!input_ready && i < 4000) begin
         if (show_valid && !prev) begin
            if (ts < 0) ts = i;
            if (ncap < 16) cap[ncap] = show_sym;
            ncap++;
         end
         prev = show_valid;
         key_valid = noise && (i % 3 == 0);
         key = 2'(i);
         tick();
         i++;
      end
      key_valid = 1'b0;
      ti = i;
      chk("ir_reach", int'(input_ready), 1);
      chk("ncap", ncap, int'(lvl) + 1);
   endtask

   task automatic play_all();
      for (int i = 0; i < ncap; i++) begin
         press(cap[i]);
         if (i < ncap - 1) chk("prog_step", int'(progress), i + 1);
      end
      chk("win_pulse", int'(win), 1);
      tick();
      chk("win_once", int'(win), 0);
      chk("idle_after", int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; auth_bit = 1'b1; log_out = 1'b0; start = 1'b0;
      level_num = 4'd0; key_valid = 1'b0; key = 2'b00;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_sv", int'(show_valid), 0);
      chk("rst_sym", int'(show_sym), 0);
      chk("rst_prog", int'(progress), 0);
      rst = 1'b0;
      tick();

      // level 3 full round
      run_to_input(4'd3, 1'b0, t_show, t_ir);
      chk("t_show_l3", t_show, 4);
      chk("t_ir_l3", t_ir, 52);
      play_all();
      tick();

      // level 2, wrong second key
      run_to_input(4'd2, 1'b0, t_show, t_ir);
      press(cap[0]);
      chk("prog_1", int'(progress), 1);
      press(~cap[1]);
      chk("lose_pulse", int'(lose), 1);
      chk("lose_prog", int'(progress), 1);
      tick();
      chk("lose_once", int'(lose), 0);
      chk("lose_idle", int'(busy), 0);

      // log_out during SHOW
      level_num = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!show_valid && n < 100) begin tick(); n++; end
      repeat (2) tick();
      log_out = 1'b1;
      tick();
      log_out = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_sv", int'(show_valid), 0);
      repeat (3) tick();

      // log_out coincident with final correct key
      run_to_input(4'd1, 1'b0, t_show, t_ir);
      press(cap[0]);
      key = cap[1]; key_valid = 1'b1; log_out = 1'b1;
      tick();
      key_valid = 1'b0; log_out = 1'b0;
      chk("abort_win", int'(win), 0);
      chk("abort_prog", int'(progress), 0);
      chk("abort_idle", int'(busy), 0);
      tick();

      // start without auth, keys in IDLE and SHOW ignored
      auth_bit = 1'b0; start = 1'b1; level_num = 4'd3;
      repeat (3) tick();
      chk("noauth_busy", int'(busy), 0);
      start = 1'b0; auth_bit = 1'b1;
      tick();
      press(2'd1);
      press(2'd2);
      chk("idle_keys", int'(progress), 0);
      run_to_input(4'd2, 1'b1, t_show, t_ir);
      chk("show_keys", int'(progress), 0);
      play_all();

      // longest sequence
      run_to_input(4'd15, 1'b0, t_show, t_ir);
      chk("t_ir_l15", t_ir, 16 + 16 * (SC + GC));
      play_all();

`ifdef ROUND_TIMEOUT_EN
      run_to_input(4'd1, 1'b0, t_show, t_ir);
      n = 0;
      while (!lose && n < 200) begin tick(); n++; end
      chk("timeout_at", n, 64);
      tick();
      chk("timeout_idle", int'(busy), 0);
      run_to_input(4'd1, 1'b0, t_show, t_ir);
      repeat (59) tick();
      press(cap[0]);
      chk("slow_prog", int'(progress), 1);
      repeat (59) tick();
      press(cap[1]);
      chk("slow_win", int'(win), 1);
      tick();
`else
      run_to_input(4'd1, 1'b0, t_show, t_ir);
      repeat (100) tick();
      chk("ir_hold", int'(input_ready), 1);
      log_out = 1'b1;
      tick();
      log_out = 1'b0;
      chk("hold_abort", int'(busy), 0);
      tick();
`endif

      // reset asserted mid-GAP
      level_num = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!show_valid && n < 100) begin tick(); n++; end
      while (show_valid && n < 200) begin tick(); n++; end
      chk("gap_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_sv", int'(show_valid), 0);
      chk("arst_sym", int'(show_sym), 0);
      chk("arst_ir", int'(input_ready), 0);
      chk("arst_prog", int'(progress), 0);
      chk("arst_win", int'(win), 0);
      chk("arst_lose", int'(lose), 0);
      @(posedge clock);
      #1 rst = 1'b0;
      tick();

      // single-symbol round after reset
      run_to_input(4'd0, 1'b0, t_show, t_ir);
      chk("t_show_l0", t_show, 1);
      chk("t_ir_l0", t_ir, 13);
      play_all();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_round_engine.md
# memory_round_engine

Plays one round of the memory-tester game: it takes the current player's `level_num` from the level table, generates a pseudo-random symbol sequence whose length grows with level, and presents it on the display interface. It then checks the player's key entries against that sequence. The result is reported as the one-cycle `win` or `lose` pulse that the level table consumes to update the player's level. It sits between the level table and the display/keypad front end.

## Interface
Parameters:
- `SHOW_CYCLES`, 8 — cycles each symbol is displayed (≥1)
- `GAP_CYCLES`, 4 — blank cycles after each displayed symbol (≥1)
- `TIMEOUT_CYCLES`, 64 — idle cycles allowed between keys in the input phase (≥2; used only with `ROUND_TIMEOUT_EN`)
- `LFSR_SEED`, 16'hACE1 — LFSR reset value (non-zero)

Ports:
- `clock` input 1 — single clock; everything is rising-edge
- `rst` input 1 — asynchronous, active-high reset
- `auth_bit` input 1 — player authenticated; low forces IDLE
- `log_out` input 1 — abort the round and return to IDLE
- `start` input 1 — request a round; sampled in IDLE only
- `level_num` input 4 — level from the level table, captured at start
- `key_valid` input 1 — one-cycle key press strobe
- `key` input 2 — symbol of the key pressed
- `show_valid` output 1 — `show_sym` is being displayed
- `show_sym` output 2 — symbol being displayed
- `input_ready` output 1 — engine is accepting keys
- `progress` output 4 — count of correct keys entered so far
- `busy` output 1 — engine is not in IDLE
- `win` output 1 — one-cycle pulse: whole sequence matched
- `lose` output 1 — one-cycle pulse: mismatch or timeout

## Operation
- Sequence length: L = `level_num` + 1 (1..16). `level_num` is captured at start and is not re-read during the round.
- Storage: 16 × 2-bit sequence RAM, index counter, phase counter.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle from reset, including IDLE. Symbol = LFSR[1:0].
- States and transitions:
  - IDLE → GEN on `start`=1 with `auth_bit`=1.
  - GEN: writes one symbol per cycle to index 0..L-1, then → SHOW.
  - SHOW: holds `show_valid`=1 with `show_sym`=seq[idx] for SHOW_CYCLES, then → GAP.
  - GAP: holds `show_valid`=0 for GAP_CYCLES. Then → SHOW with idx+1, or → INPUT after idx L-1.
  - INPUT: `input_ready`=1. On `key_valid`, compares `key` with seq[`progress`].
    - Match and `progress`=L-1 → WIN.
    - Match otherwise → `progress`+1.
    - Mismatch → LOSE.
  - WIN/LOSE: last one cycle, with `win`/`lose`=1, then → IDLE.
- Abort: `log_out`=1 or `auth_bit`=0 in any state → IDLE next cycle. No `win`/`lose` pulse is produced. `progress` and idx clear.
- Priority: abort > key evaluation. `log_out` coincident with a final correct key gives no `win`.
- `key_valid` outside INPUT is ignored. `start` outside IDLE is ignored.
- `win` and `lose` are never high together and are never high for two consecutive cycles.

## Timing
- Reset values:
  - state IDLE
  - LFSR = `LFSR_SEED`
  - `show_valid` = `input_ready` = `busy` = `win` = `lose` = 0
  - `show_sym` = 0, `progress` = 0
  - sequence RAM contents don't-care
- All outputs are registered.
- Start accepted at edge 0 gives `busy`=1 from edge 1.
- `show_valid` first rises at edge 1+L.
- `input_ready` rises at edge 1+L+L·(SHOW_CYCLES+GAP_CYCLES).
- A key accepted at edge k updates `progress`, or asserts `win`/`lose`, at edge k+1.
- After a `win`/`lose` pulse at edge k, IDLE is reached at edge k+1. A new `start` is sampled from edge k+1.
- Reset asserted mid-round returns to IDLE asynchronously with the reset values above.

## Configuration
- `ROUND_TIMEOUT_EN` defined:
  - In INPUT, a counter clears on entry and on every accepted key.
  - If TIMEOUT_CYCLES cycles pass with no `key_valid` → LOSE.
  - A key arriving on the expiry cycle is evaluated; the timeout is not taken.
- `ROUND_TIMEOUT_EN` undefined: no counter; INPUT waits indefinitely for keys or an abort.

## Test plan
- `level_num`=3, `start` pulse with `auth_bit`=1, defaults → `busy` at edge 1; four symbols of 8 cycles each separated by 4-cycle gaps; `input_ready` at edge 53. Replaying the four captured `show_sym` values gives `progress` 1,2,3 then `win` for exactly one cycle, then IDLE.
- `level_num`=0, second key wrong → only one key is needed. Bench variant: on `level_num`=2, a wrong 2nd key → `lose` one cycle after it, `progress` held at 1, then IDLE.
- `log_out` pulse during SHOW, and separately coincident with the final correct key → IDLE next cycle, no `win`/`lose`, `progress`=0.
- `auth_bit`=0 while `start`=1 → stays IDLE, `busy`=0. Keys pressed in IDLE/SHOW → ignored, `progress` stays 0.
- `ROUND_TIMEOUT_EN` defined, level 1, no keys → `lose` exactly 64 cycles after `input_ready` rises. A key every 60 cycles → no timeout, `win`.
- Assert `rst` mid-GAP → all outputs return to reset values immediately. A subsequent `start` runs a full round normally.
